shifter_arbiter: RTL

//   Shares one N-bit shift datapath (SLL/SRL/SRA; shift amount 0..N-1) between two requesters.

---
 rtl/shifter_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/shifter_arbiter.sv
// Two-requester round-robin front end sharing one SLL/SRL/SRA shifter,
// feeding a single-entry registered output slot with valid/ready backpressure.
module shifter_arbiter #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [N-1:0]         req0_in,
  input  logic [$clog2(N)-1:0] req0_shamt,
  input  logic [1:0]           req0_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [N-1:0]         req1_in,
  input  logic [$clog2(N)-1:0] req1_shamt,
  input  logic [1:0]           req1_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_id
);
  localparam int SW = $clog2(N);

  typedef struct packed {
    logic [N-1:0]  data;
    logic [SW-1:0] shamt;
    logic [1:0]    op;
  } req_t;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t       state;
  logic         last_grant;
  logic         can_accept, any_valid, grant, fire;
  req_t         r0, r1, sel;
  logic [N-1:0] result;

  assign r0 = '{data: req0_in, shamt: req0_shamt, op: req0_op};
  assign r1 = '{data: req1_in, shamt: req1_shamt, op: req1_op};

  assign out_valid  = (state == FULL);
  assign can_accept = !out_valid || out_ready;
  assign any_valid  = req0_valid || req1_valid;
  // Tie goes to whoever did not win last; otherwise the lone requester.
  assign grant      = (req0_valid && req1_valid) ? !last_grant : req1_valid;
  // Gating with rst keeps a request from being handshaken during the reset cycle.
  assign fire       = rst && can_accept && any_valid;
  assign req0_ready = fire && !grant;
  assign req1_ready = fire &&  grant;

  assign sel = grant ? r1 : r0;

  always_comb begin
    result = sel.data;
    unique case (sel.op)
      2'b00:   result = sel.data << sel.shamt;
      2'b01:   result = sel.data >> sel.shamt;
      2'b10:   result = N'($signed(sel.data) >>> sel.shamt);
      default: result = sel.data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (fire) begin
      state      <= FULL;
      out_data   <= result;
      out_id     <= grant;
      last_grant <= grant;
    end else if (out_ready) begin
      // Drained with nothing behind it; data/id keep their last value.
      state <= EMPTY;
    end
  end
endmodule
